// File: rtl/conv_encoder_stream.sv
// Rate-1/3, K=7 convolutional encoder (G 133/171/165 octal), P bits per word,
// valid/ready streaming with tail-biting or zero-state start.
module conv_encoder_stream #(
    parameter int unsigned P     = 8,
    parameter int unsigned LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             tb_mode,
    input  logic [5:0]       tail_in,
    input  logic [LEN_W-1:0] blk_len_words,
    input  logic [P-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [P-1:0]     d0,
    output logic [P-1:0]     d1,
    output logic [P-1:0]     d2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned SW = 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state,     state_nxt;
    logic [SW-1:0]    st,        st_nxt;      // st[0] = s1 (most recent bit)
    logic [LEN_W-1:0] cnt,       cnt_nxt;
    logic [LEN_W-1:0] len_q,     len_nxt;
    logic [P-1:0]     d0_nxt,    d1_nxt,    d2_nxt;
    logic             out_valid_nxt, out_last_nxt, busy_nxt, done_nxt;

    logic [P-1:0]     enc_d0, enc_d1, enc_d2;
    logic [SW-1:0]    enc_st;
    logic             in_hs, out_hs;

    assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Bit-serial encoder unrolled across the word, bit 0 first in time
    always_comb begin
        logic [SW-1:0] s_v;
        logic          u;
        s_v    = st;
        u      = 1'b0;
        enc_d0 = '0;
        enc_d1 = '0;
        enc_d2 = '0;
        for (int unsigned i = 0; i < P; i++) begin
            u         = in_data[i];
            enc_d0[i] = u ^ s_v[1] ^ s_v[2] ^ s_v[4] ^ s_v[5];
            enc_d1[i] = u ^ s_v[0] ^ s_v[1] ^ s_v[2] ^ s_v[5];
            enc_d2[i] = u ^ s_v[0] ^ s_v[1] ^ s_v[3] ^ s_v[5];
            s_v       = {s_v[SW-2:0], u};
        end
        enc_st = s_v;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt     = state;
        st_nxt        = st;
        cnt_nxt       = cnt;
        len_nxt       = len_q;
        d0_nxt        = d0;
        d1_nxt        = d1;
        d2_nxt        = d2;
        out_valid_nxt = out_valid;
        out_last_nxt  = out_last;
        busy_nxt      = busy;
        done_nxt      = 1'b0;

        case (state)
            S_IDLE: begin
                // busy lingers through the done cycle so a start there is ignored
                busy_nxt = 1'b0;
                if (start && !busy && (blk_len_words != '0)) begin
                    len_nxt   = blk_len_words;
                    st_nxt    = tb_mode ? tail_in : '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (out_hs) begin
                    out_valid_nxt = 1'b0;
                end
                if (in_hs) begin
                    d0_nxt        = enc_d0;
                    d1_nxt        = enc_d1;
                    d2_nxt        = enc_d2;
                    out_valid_nxt = 1'b1;
                    st_nxt        = enc_st;
                    cnt_nxt       = cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) begin
                        out_last_nxt = 1'b1;
                        state_nxt    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_hs && out_last) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    done_nxt      = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            st        <= '0;
            cnt       <= '0;
            len_q     <= '0;
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            st        <= st_nxt;
            cnt       <= cnt_nxt;
            len_q     <= len_nxt;
            d0        <= d0_nxt;
            d1        <= d1_nxt;
            d2        <= d2_nxt;
            out_valid <= out_valid_nxt;
            out_last  <= out_last_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Scoreboard bench for conv_encoder_stream: bit-serial generator model feeds an
// expected-word queue; output handshakes pop and compare.
module tb_conv_encoder_stream;

    localparam int unsigned P     = 8;
    localparam int unsigned LEN_W = 10;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       last;
    } word_t;

    logic             clk = 1'b0;
    logic             reset, start, tb_mode, in_valid, out_ready;
    logic [5:0]       tail_in;
    logic [LEN_W-1:0] blk_len_words;
    logic [P-1:0]     in_data, d0, d1, d2;
    logic             in_ready, out_valid, out_last, busy, done;

    conv_encoder_stream #(.P(P), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .tb_mode(tb_mode),
        .tail_in(tail_in), .blk_len_words(blk_len_words),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .d0(d0), .d1(d1), .d2(d2), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    checks = 0;
    int    errors = 0;
    word_t sb_q[$];
    word_t obs_q[$];
    int    last_out_cyc = 0;
    int    last_acc_cyc = 0;
    logic [5:0] m_state;
    int    m_len, m_idx;

    function automatic word_t mk(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input logic l);
        word_t w;
        w.d0 = a; w.d1 = b; w.d2 = c; w.last = l;
        return w;
    endfunction

    // Reference: taps read from the octal generators, MSB = current input bit
    function automatic word_t model_word(input logic [7:0] data, input logic [5:0] st_in,
                                         input logic last, output logic [5:0] st_out);
        logic [6:0] h, g0, g1, g2;
        word_t w;
        g0 = 7'o133; g1 = 7'o171; g2 = 7'o165;
        h  = {st_in, 1'b0};
        w  = '0;
        for (int i = 0; i < 8; i++) begin
            h[0] = data[i];
            for (int d = 0; d < 7; d++) begin
                w.d0[i] = w.d0[i] ^ (g0[6-d] & h[d]);
                w.d1[i] = w.d1[i] ^ (g1[6-d] & h[d]);
                w.d2[i] = w.d2[i] ^ (g2[6-d] & h[d]);
            end
            h = {h[5:0], 1'b0};
        end
        w.last = last;
        st_out = h[6:1];
        return w;
    endfunction

    task automatic mon_loop();
        word_t got, exp;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                got = {d0, d1, d2, out_last};
                obs_q.push_back(got);
                last_out_cyc = cyc;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got d0=%h d1=%h d2=%h last=%b, expected no word",
                             got.d0, got.d1, got.d2, got.last);
                end else begin
                    exp = sb_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sb_word: got d0=%h d1=%h d2=%h last=%b, expected d0=%h d1=%h d2=%h last=%b",
                                 got.d0, got.d1, got.d2, got.last, exp.d0, exp.d1, exp.d2, exp.last);
                    end
                end
            end
        end
    endtask

    task automatic start_block(input logic tb, input logic [5:0] tail, input int len);
        start = 1'b1; tb_mode = tb; tail_in = tail; blk_len_words = LEN_W'(len);
        @(posedge clk); #1;
        start   = 1'b0;
        m_state = tb ? tail : 6'd0;
        m_len   = len;
        m_idx   = 0;
        obs_q.delete();
    endtask

    task automatic send_word(input logic [7:0] data);
        logic ok;
        logic [5:0] ns;
        word_t w;
        ok = 1'b0; in_data = data; in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                w = model_word(data, m_state, (m_idx == m_len - 1), ns);
                m_state = ns;
                m_idx++;
                sb_q.push_back(w);
                last_acc_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL in_accept: word %h not accepted, required acceptance within 100 cycles", data);
        end
    endtask

    task automatic wait_done(output int dcyc, output logic seen);
        seen = 1'b0; dcyc = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1; dcyc = cyc;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: done=0 after 200 cycles, required 1");
        end
    endtask

    task automatic check_count(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, in_ready, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid/last/in_ready/busy/done=%b, required 00000",
                     {out_valid, out_last, in_ready, busy, done});
        end
        checks++;
        if ({d0, d1, d2} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: d0/d1/d2=%h, required 000000", {d0, d1, d2});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_block();
        int dc; logic seen;
        start_block(1'b0, 6'd0, 5);
        for (int i = 0; i < 5; i++) send_word(8'h00);
        wait_done(dc, seen);
        checks++;
        if (dc != last_out_cyc + 1) begin
            errors++;
            $display("FAIL done_timing: done at cycle %0d, required %0d", dc, last_out_cyc + 1);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_done: busy=%b, required 1", busy);
        end
        // start in the done cycle must be ignored
        start = 1'b1; blk_len_words = LEN_W'(3); tb_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done: busy=%b done=%b, required 0 0", busy, done);
        end
        check_count("zero_count", obs_q.size(), 5);
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== mk(8'h00, 8'h00, 8'h00, (i == 4))) begin
                errors++;
                $display("FAIL zero_word%0d: got %h, required %h", i, obs_q[i], mk(8'h00, 8'h00, 8'h00, (i == 4)));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_impulse(input string name);
        int dc; logic seen;
        start_block(1'b0, 6'd0, 5);
        send_word(8'h01);
        for (int i = 0; i < 4; i++) send_word(8'h00);
        wait_done(dc, seen);
        check_count({name, "_count"}, obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            checks++;
            if (obs_q[0] !== mk(8'h6D, 8'h4F, 8'h57, 1'b0)) begin
                errors++;
                $display("FAIL %s_word0: got %h, required %h", name, obs_q[0], mk(8'h6D, 8'h4F, 8'h57, 1'b0));
            end
            checks++;
            if (obs_q[1] !== mk(8'h00, 8'h00, 8'h00, 1'b0)) begin
                errors++;
                $display("FAIL %s_word1: got %h, required 0", name, obs_q[1]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tailbiting();
        int dc; logic seen;
        start_block(1'b1, 6'b000001, 5);
        for (int i = 0; i < 4; i++) send_word(8'h00);
        send_word(8'h80);
        wait_done(dc, seen);
        check_count("tb_count", obs_q.size(), 5);
        if (obs_q.size() == 5) begin
            checks++;
            if (obs_q[0] !== mk(8'h36, 8'h27, 8'h2B, 1'b0)) begin
                errors++;
                $display("FAIL tb_word0: got %h, required %h", obs_q[0], mk(8'h36, 8'h27, 8'h2B, 1'b0));
            end
            checks++;
            if (obs_q[4] !== mk(8'h80, 8'h80, 8'h80, 1'b1)) begin
                errors++;
                $display("FAIL tb_word4: got %h, required %h", obs_q[4], mk(8'h80, 8'h80, 8'h80, 1'b1));
            end
            checks++;
            if (obs_q[2] !== mk(8'h00, 8'h00, 8'h00, 1'b0)) begin
                errors++;
                $display("FAIL tb_word2: got %h, required 0", obs_q[2]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int dc; logic seen;
        word_t snap;
        start_block(1'b0, 6'd0, 8);
        fork
            begin
                for (int i = 0; i < 8; i++) send_word(8'($urandom));
            end
            begin
                for (int k = 0; k < 200 && obs_q.size() < 3; k++) begin
                    @(posedge clk); #1;
                end
                out_ready = 1'b0;
                @(negedge clk);
                snap = {d0, d1, d2, out_last};
                for (int j = 0; j < 3; j++) begin
                    if (j > 0) @(negedge clk);
                    checks++;
                    if (!out_valid || in_ready || ({d0, d1, d2, out_last} !== snap)) begin
                        errors++;
                        $display("FAIL stall%0d: valid=%b in_ready=%b word=%h, required 1 0 %h",
                                 j, out_valid, in_ready, {d0, d1, d2, out_last}, snap);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done(dc, seen);
        check_count("bp_count", obs_q.size(), 8);
        check_count("bp_sb_left", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int dc, first; logic seen;
        start_block(1'b1, 6'($urandom), 6);
        send_word(8'($urandom));
        first = last_acc_cyc;
        for (int i = 0; i < 5; i++) send_word(8'($urandom));
        check_count("b2b_span", last_acc_cyc - first, 5);
        wait_done(dc, seen);
        check_count("b2b_count", obs_q.size(), 6);
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int dc; logic seen;
        start_block(1'b0, 6'd0, 4);
        send_word(8'hA5);
        send_word(8'h3C);
        start = 1'b1; blk_len_words = LEN_W'(9); tb_mode = 1'b1; tail_in = 6'h3F;
        @(posedge clk); #1;
        start = 1'b0;
        send_word(8'hF0);
        send_word(8'h0F);
        wait_done(dc, seen);
        check_count("ign_count", obs_q.size(), 4);
        @(posedge clk); #1;
        // zero-length start in IDLE, with stray in_valid
        start = 1'b1; blk_len_words = '0; tb_mode = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0: busy=%b in_ready=%b out_valid=%b, required 0 0 0", busy, in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midblock();
        start_block(1'b0, 6'd0, 5);
        send_word(8'h5A);
        send_word(8'h3C);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_last, in_ready, busy, done} !== 5'b0 || {d0, d1, d2} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset: ctrl=%b data=%h, required 00000 000000",
                     {out_valid, out_last, in_ready, busy, done}, {d0, d1, d2});
        end
        reset = 1'b0;
        sb_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset%0d: done=%b busy=%b, required 0 0", k, done, busy);
            end
        end
        @(posedge clk); #1;
        run_impulse("post_reset");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tb_mode = 1'b0; tail_in = '0;
        blk_len_words = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        m_state = '0; m_len = 0; m_idx = 0;
        fork
            mon_loop();
        join_none
        test_reset();
        test_zero_block();
        run_impulse("impulse");
        test_tailbiting();
        test_backpressure();
        test_back_to_back();
        test_start_ignored();
        test_reset_midblock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
